// File: rtl/gpio0_clkout_pkg.sv
// gpio0_clkout_pkg: shared FSM encoding and ctrl bit positions for the GPIO0 clock-out generator.
package gpio0_clkout_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, BURST = 2'd2, STOP = 2'd3} state_t;
  localparam int CTRL_RUN = 0;
  localparam int CTRL_BURST = 1;
endpackage

// File: rtl/gpio0_clkout_halfcnt.sv
// gpio0_clkout_halfcnt: half-period counter; div_q is re-sampled only at half boundaries or on load.
module gpio0_clkout_halfcnt #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic             en,
  input  logic [DIV_W-1:0] div_half,
  output logic             half_end
);
  logic [DIV_W-1:0] cnt, div_q;
  assign half_end = en && cnt == div_q;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      cnt   <= '0;
      div_q <= '0;
    end else if (load || half_end) begin
      cnt   <= '0;
      div_q <= div_half;
    end else if (en) begin
      cnt   <= cnt + 1'b1;
    end
endmodule

// File: rtl/gpio0_clkout_gen.sv
// gpio0_clkout_gen: glitch-free programmable clock on the GPIO0 CLKOUT pins, continuous or burst of N periods.
module gpio0_clkout_gen
  import gpio0_clkout_pkg::*;
#(
  parameter int DIV_W   = 16,
  parameter int BURST_W = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [1:0]         ctrl,
  input  logic [DIV_W-1:0]   div_half,
  input  logic [BURST_W-1:0] burst_len,
  output logic [1:0]         clkout,
  output logic               busy,
  output logic               burst_done
);
  state_t state, state_n;
  logic phase, phase_n, ctrl_d, done_n, half_end, low_end, start;
  logic [BURST_W-1:0] rem, rem_n;
  logic [1:0] clkout_n;
  assign start   = state == IDLE && ctrl[CTRL_RUN] && !ctrl_d;
  assign low_end = half_end && !phase;
  gpio0_clkout_halfcnt #(.DIV_W(DIV_W)) u_halfcnt (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (start),
    .en       (state != IDLE),
    .div_half (div_half),
    .half_end (half_end)
  );
  always_comb begin
    state_n = state;
    phase_n = half_end ? ~phase : phase;
    rem_n   = rem;
    done_n  = 1'b0;
    case (state)
      IDLE:
        if (start) begin
          state_n = ctrl[CTRL_BURST] ? BURST : RUN;
          phase_n = !(ctrl[CTRL_BURST] && burst_len == '0);
          rem_n   = burst_len;
        end
      RUN: state_n = ctrl[CTRL_RUN] ? RUN : STOP;
      BURST:
        // a burst completing on this edge wins over an abort request
        if (rem == '0 || (low_end && rem == BURST_W'(1))) begin
          state_n = IDLE;
          done_n  = 1'b1;
          rem_n   = '0;
        end else begin
          rem_n   = low_end ? rem - 1'b1 : rem;
          state_n = ctrl[CTRL_RUN] ? BURST : STOP;
        end
      STOP: state_n = low_end ? IDLE : STOP;
      default: state_n = IDLE;
    endcase
    if (state_n == IDLE) phase_n = 1'b0;
    // a zero-length burst is active for one cycle but must never drive the pins
    clkout_n = (state_n == IDLE || (state_n == BURST && rem_n == '0)) ? 2'b00 : {~phase_n, phase_n};
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state      <= IDLE;
      phase      <= 1'b0;
      rem        <= '0;
      ctrl_d     <= 1'b0;
      clkout     <= 2'b00;
      busy       <= 1'b0;
      burst_done <= 1'b0;
    end else begin
      state      <= state_n;
      phase      <= phase_n;
      rem        <= rem_n;
      ctrl_d     <= ctrl[CTRL_RUN];
      clkout     <= clkout_n;
      busy       <= state_n != IDLE;
      burst_done <= done_n;
    end
endmodule

// File: tb/tb_gpio0_clkout_gen.sv
// tb_gpio0_clkout_gen: directed stimulus, cycle model of the pin waveform, plus literal waveform statistics.
module tb_gpio0_clkout_gen;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [1:0] ctrl = 2'b00;
  logic [15:0] div_half = 16'd0;
  logic [15:0] burst_len = 16'd0;
  logic [1:0] clkout;
  logic busy, burst_done;
  int n_chk = 0, n_fail = 0;
  int n_high, n_low, n_busy, n_done, n_rise;
  logic prev0 = 1'b0;
  int m_mode, m_left, m_per;
  bit m_lvl, m_prev, low_done;
  logic [1:0] e_clk = 2'b00;
  logic e_busy = 1'b0, e_done = 1'b0;

  always #5 clk = ~clk;

  gpio0_clkout_gen dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .ctrl       (ctrl),
    .div_half   (div_half),
    .burst_len  (burst_len),
    .clkout     (clkout),
    .busy       (busy),
    .burst_done (burst_done)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic clr();
    n_high = 0; n_low = 0; n_busy = 0; n_done = 0; n_rise = 0;
  endtask

  task automatic wait_idle();
    int c;
    c = 0;
    while (busy && c < 200) begin
      step(1);
      c++;
    end
    chk("idle_within_bound", busy, 0);
    step(2);
  endtask

  // model: mode 0 idle, 1 run, 2 burst, 3 stopping; m_left counts cycles left in the current half
  initial forever begin
    @(posedge clk or negedge reset_n);
    if (!reset_n) begin
      m_mode = 0; m_left = 0; m_per = 0; m_lvl = 0; m_prev = 0;
      e_clk = 2'b00; e_busy = 0; e_done = 0;
    end else begin
      e_done = 0;
      low_done = 0;
      if (m_mode == 0) begin
        if (ctrl[0] && !m_prev) begin
          m_mode = ctrl[1] ? 2 : 1;
          m_per  = burst_len;
          m_lvl  = !(ctrl[1] && burst_len == 0);
          m_left = div_half + 1;
        end
      end else begin
        m_left--;
        if (m_left == 0) begin
          low_done = !m_lvl;
          m_lvl = !m_lvl;
          m_left = div_half + 1;
        end
        if (m_mode == 2) begin
          if (low_done) m_per--;
          if (m_per <= 0) begin
            m_mode = 0;
            e_done = 1;
          end else if (!ctrl[0]) m_mode = 3;
        end else if (m_mode == 1) begin
          if (!ctrl[0]) m_mode = 3;
        end else if (low_done) m_mode = 0;
      end
      m_prev = ctrl[0];
      e_busy = m_mode != 0;
      e_clk  = (m_mode == 0 || (m_mode == 2 && m_per == 0)) ? 2'b00 : {!m_lvl, m_lvl};
    end
  end

  initial forever begin
    @(negedge clk);
    if (clkout == 2'b01) n_high++;
    if (clkout == 2'b10) n_low++;
    if (busy) n_busy++;
    if (burst_done) n_done++;
    if (clkout[0] && !prev0) n_rise++;
    prev0 = clkout[0];
    chk("model_clkout", clkout, e_clk);
    chk("model_busy", busy, e_busy);
    chk("model_burst_done", burst_done, e_done);
  end

  initial begin
    clr();
    div_half = 16'd3;
    step(3);
    chk("reset_clkout", clkout, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", burst_done, 0);
    reset_n = 1'b1;
    step(2);
    // async reset in the middle of a run
    div_half = 16'd2;
    ctrl = 2'b01;
    step(5);
    chk("t1_active", busy, 1);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("t1_async_clkout", clkout, 0);
    chk("t1_async_busy", busy, 0);
    chk("t1_async_done", burst_done, 0);
    step(1);
    ctrl = 2'b00;
    reset_n = 1'b1;
    step(2);
    // continuous, div_half=3, stop requested in 2nd high cycle of period 3
    div_half = 16'd3;
    clr();
    ctrl = 2'b01;
    step(1);
    chk("t2_first_high", clkout, 2'b01);
    step(17);
    ctrl = 2'b00;
    step(2);
    ctrl = 2'b01;
    step(1);
    ctrl = 2'b00;
    wait_idle();
    chk("t2_high_cycles", n_high, 12);
    chk("t2_low_cycles", n_low, 12);
    chk("t2_busy_cycles", n_busy, 24);
    chk("t2_rises", n_rise, 3);
    chk("t2_idle_pins", clkout, 0);
    // burst of 5 periods, ctrl held high afterwards
    div_half = 16'd1;
    burst_len = 16'd5;
    clr();
    ctrl = 2'b11;
    step(40);
    chk("t3_rises", n_rise, 5);
    chk("t3_busy_cycles", n_busy, 20);
    chk("t3_done_pulses", n_done, 1);
    chk("t3_high_cycles", n_high, 10);
    ctrl = 2'b00;
    step(2);
    // divider change mid-high
    div_half = 16'd3;
    clr();
    ctrl = 2'b01;
    step(2);
    div_half = 16'd0;
    step(2);
    chk("t4_k4", clkout, 2'b01);
    step(1);
    chk("t4_k5", clkout, 2'b10);
    step(1);
    chk("t4_k6", clkout, 2'b01);
    step(1);
    chk("t4_k7", clkout, 2'b10);
    ctrl = 2'b00;
    wait_idle();
    // zero-length burst
    div_half = 16'd2;
    burst_len = 16'd0;
    clr();
    ctrl = 2'b11;
    step(1);
    chk("t5_busy", busy, 1);
    chk("t5_pins", clkout, 0);
    chk("t5_no_done_yet", burst_done, 0);
    step(1);
    chk("t5_done", burst_done, 1);
    chk("t5_idle", busy, 0);
    step(8);
    chk("t5_rises", n_rise, 0);
    chk("t5_done_pulses", n_done, 1);
    ctrl = 2'b00;
    step(2);
    // abort during period 3 of a 10-period burst
    div_half = 16'd1;
    burst_len = 16'd10;
    clr();
    ctrl = 2'b11;
    step(9);
    chk("t6_period3_high", clkout, 2'b01);
    ctrl = 2'b10;
    wait_idle();
    chk("t6_rises", n_rise, 3);
    chk("t6_done_pulses", n_done, 0);
    chk("t6_busy_cycles", n_busy, 12);
    ctrl = 2'b00;
    step(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
